// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I definitions for the memory-access stage:
//               load/store width encodings (funct3), writeback result-select
//               encodings, the memory-stage FSM state type and a funct3
//               legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Load/store width and sign encodings carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Writeback result-select encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Memory-stage bus FSM
  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  // Unsigned widths only exist for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane steering for RV32I loads and stores.
//               Ports:
//                 addr_lo    in  2   byte offset within the word
//                 funct3     in  3   width/sign encoding
//                 wdata      in  32  raw store data (rs2)
//                 rdata      in  32  raw read word from memory
//                 be         out 4   store byte enables
//                 wdata_out  out 32  lane-replicated store data
//                 rdata_ext  out 32  selected and extended load data
//                 misaligned out 1   access crosses its natural alignment
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align (
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  import riscv_pkg::*;

  // Move the addressed byte/half down to bit 0 before extension
  logic [31:0] w_shifted;
  assign w_shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b1111;
    wdata_out  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                     : {24'b0, w_shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << addr_lo;
        wdata_out  = {2{wdata[15:0]}};
        rdata_ext  = (funct3 == F3_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                      : {16'b0, w_shifted[15:0]};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RV32I memory-access stage. Issues data-memory requests,
//               steers byte lanes, stalls the pipeline while an access is
//               outstanding and owns the MEM/WB pipeline register.
//               Ports:
//                 clk, reset            clock, async active-high reset
//                 *_m                   EX/MEM instruction fields
//                 dmem_req/we/addr/wdata/be, dmem_ack/rdata   data bus
//                 stall_mem             freeze upstream stages
//                 exc_misalign, exc_bus single-cycle fault pulses
//                 *_w                   MEM/WB register to writeback
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        regwrite_m,
  input  logic [1:0]  result_src_m,
  input  logic        memread_m,
  input  logic        memwrite_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] pc_plus_4_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        exc_misalign,
  output logic        exc_bus,
  output logic        regwrite_w,
  output logic [1:0]  result_src_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] readdata_w,
  output logic [4:0]  rd_w,
  output logic [31:0] pc_plus_4_w
);
  import riscv_pkg::*;

  localparam int c_cnt_w = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  mem_state_t         r_state;
  mem_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;

  logic [3:0]  w_be;
  logic [31:0] w_wdata_out;
  logic [31:0] w_rdata_ext;
  logic        w_misaligned;

  logic w_is_mem;
  logic w_legal;
  logic w_mem_op;
  logic w_fault;
  logic w_timeout;
  logic w_req;
  logic w_stall;
  logic w_complete;
  logic w_abort;

  lsu_align u_lsu_align (
    .addr_lo    (alu_result_m[1:0]),
    .funct3     (funct3_m),
    .wdata      (write_data_m),
    .rdata      (dmem_rdata),
    .be         (w_be),
    .wdata_out  (w_wdata_out),
    .rdata_ext  (w_rdata_ext),
    .misaligned (w_misaligned)
  );

  // A load that is also a store has no meaning and is rejected as illegal
  assign w_is_mem = memread_m | memwrite_m;
  assign w_legal  = ~(memread_m & memwrite_m) & f3_legal(funct3_m, memwrite_m) & ~w_misaligned;
  assign w_mem_op = valid_m & w_is_mem & w_legal;
  assign w_fault  = valid_m & w_is_mem & ~w_legal;

  // Counter holds the number of BUSY cycles already spent waiting
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_state == MEM_BUSY) &&
                     (r_cnt == c_cnt_w'(ACK_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MEM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_mem_op) begin
          w_req = 1'b1;
          if (dmem_ack) begin
            w_complete = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = MEM_BUSY;
          end
        end else if (!w_fault) begin
          // Non-memory instruction or empty slot passes straight through
          w_complete = 1'b1;
        end
      end
      MEM_BUSY: begin
        if (w_timeout) begin
          // Request is dropped; stall released so the faulting op leaves as a bubble
          w_abort     = 1'b1;
          w_state_nxt = MEM_IDLE;
        end else begin
          w_req = 1'b1;
          if (dmem_ack) begin
            w_complete  = 1'b1;
            w_state_nxt = MEM_IDLE;
          end else begin
            w_stall = 1'b1;
          end
        end
      end
      default: w_state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((ACK_TIMEOUT != 0) && (r_state == MEM_BUSY) && w_stall) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Bus side; request and stall are masked during reset since the FSM
  // may still see a legal op on the EX/MEM inputs.
  assign dmem_req   = w_req & ~reset;
  assign stall_mem  = w_stall & ~reset;
  assign dmem_we    = memwrite_m & dmem_req;
  assign dmem_addr  = {alu_result_m[31:2], 2'b00};
  assign dmem_wdata = w_wdata_out;
  assign dmem_be    = memwrite_m ? w_be : 4'b1111;

  // MEM/WB register: loads every edge; only regwrite_w qualifies the payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_w   <= 1'b0;
      result_src_w <= 2'b00;
      alu_result_w <= 32'b0;
      readdata_w   <= 32'b0;
      rd_w         <= 5'b0;
      pc_plus_4_w  <= 32'b0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
    end else begin
      regwrite_w   <= w_complete & valid_m & regwrite_m;
      result_src_w <= result_src_m;
      alu_result_w <= alu_result_m;
      readdata_w   <= w_rdata_ext;
      rd_w         <= rd_m;
      pc_plus_4_w  <= pc_plus_4_m;
      exc_misalign <= (r_state == MEM_IDLE) & w_fault;
      exc_bus      <= w_abort;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Directed scenarios plus
//               randomized instructions compared against an arithmetic
//               reference model of RV32I load/store behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import riscv_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, regwrite_m, memread_m, memwrite_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus_4_m;
  logic [4:0]  rd_m;
  logic        dmem_req, dmem_we, dmem_ack, stall_mem, exc_misalign, exc_bus;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        regwrite_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w, readdata_w, pc_plus_4_w;
  logic [4:0]  rd_w;

  int checks = 0;
  int errors = 0;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .regwrite_m(regwrite_m),
    .result_src_m(result_src_m), .memread_m(memread_m), .memwrite_m(memwrite_m),
    .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .rd_m(rd_m), .pc_plus_4_m(pc_plus_4_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus), .regwrite_w(regwrite_w),
    .result_src_w(result_src_w), .alu_result_w(alu_result_w), .readdata_w(readdata_w),
    .rd_w(rd_w), .pc_plus_4_w(pc_plus_4_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction

  function automatic bit m_legal(input bit mr, input bit mw, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (mr && mw) return 1'b0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (mw && f3 > 3'd2) return 1'b0;
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [31:0] v;
    int sh;
    sh = (a % 4) * 8;
    v  = rdata;
    case (f3)
      3'd0: begin v = (rdata >> sh) % 256;   if (v >= 128)   v = v - 256;   end
      3'd4: v = (rdata >> sh) % 256;
      3'd1: begin v = (rdata >> sh) % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = (rdata >> sh) % 65536;
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 3 : 15;
    return 4'(n << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd % 256) * 32'h01010101;
    if (f3 == 3'd1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  // Runs one instruction through the stage. Called just after a rising edge.
  task automatic do_op(input string t, input bit vld, input bit mr, input bit mw,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rdn, input bit rw, input logic [1:0] rs,
                       input int delay, input logic [31:0] rdata);
    bit is_mem;
    bit legal;
    logic [31:0] pc4;
    is_mem = mr | mw;
    legal  = m_legal(mr, mw, f3, addr);
    pc4    = $urandom;
    valid_m = vld; memread_m = mr; memwrite_m = mw; funct3_m = f3;
    alu_result_m = addr; write_data_m = wd; rd_m = rdn; regwrite_m = rw;
    result_src_m = rs; pc_plus_4_m = pc4; dmem_rdata = rdata; dmem_ack = 1'b0;
    if (vld && is_mem && !legal) begin
      @(negedge clk);
      chk({t, " fault_req"}, dmem_req, 0);
      chk({t, " fault_stall"}, stall_mem, 0);
      @(posedge clk); #1;
      chk({t, " exc_misalign"}, exc_misalign, 1);
      chk({t, " fault_regwrite_w"}, regwrite_w, 0);
      valid_m = 1'b0; memread_m = 1'b0; memwrite_m = 1'b0;
      @(posedge clk); #1;
      chk({t, " exc_misalign_once"}, exc_misalign, 0);
    end else if (vld && is_mem) begin
      for (int k = 0; k <= delay; k++) begin
        dmem_ack = (k == delay);
        @(negedge clk);
        chk({t, " req"}, dmem_req, 1);
        chk({t, " stall"}, stall_mem, (k < delay) ? 1 : 0);
        if (k == 0) begin
          chk({t, " we"}, dmem_we, mw);
          chk({t, " addr"}, dmem_addr, addr - (addr % 4));
          chk({t, " be"}, dmem_be, mw ? m_be(f3, addr) : 4'hF);
          if (mw) chk({t, " wdata"}, dmem_wdata, m_wdata(f3, wd));
        end
        @(posedge clk); #1;
        if (k < delay) chk({t, " stall_regwrite_w"}, regwrite_w, 0);
      end
      dmem_ack = 1'b0;
      chk({t, " regwrite_w"}, regwrite_w, rw);
      chk({t, " rd_w"}, rd_w, rdn);
      chk({t, " result_src_w"}, result_src_w, rs);
      chk({t, " exc_misalign_idle"}, exc_misalign, 0);
      if (mr) chk({t, " readdata_w"}, readdata_w, m_load(rdata, addr, f3));
    end else begin
      @(negedge clk);
      chk({t, " noreq"}, dmem_req, 0);
      chk({t, " nostall"}, stall_mem, 0);
      @(posedge clk); #1;
      chk({t, " regwrite_w"}, regwrite_w, (vld && rw) ? 1 : 0);
      if (vld) begin
        chk({t, " alu_result_w"}, alu_result_w, addr);
        chk({t, " pc_plus_4_w"}, pc_plus_4_w, pc4);
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    valid_m = 0; regwrite_m = 0; memread_m = 0; memwrite_m = 0; result_src_m = 0;
    funct3_m = 0; alu_result_m = 0; write_data_m = 0; rd_m = 0; pc_plus_4_m = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst regwrite_w", regwrite_w, 0);
    chk("rst readdata_w", readdata_w, 0);
    chk("rst exc_misalign", exc_misalign, 0);
    chk("rst exc_bus", exc_bus, 0);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst stall_mem", stall_mem, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    do_op("lw_fast", 1, 1, 0, F3_W, 32'h100, 0, 5'd3, 1, RES_MEM, 0, 32'hDEADBEEF);
    chk("lw_fast const", readdata_w, 32'hDEADBEEF);
    do_op("lb", 1, 1, 0, F3_B, 32'h103, 0, 5'd4, 1, RES_MEM, 0, 32'h80FF0000);
    chk("lb const", readdata_w, 32'hFFFFFF80);
    do_op("lbu", 1, 1, 0, F3_BU, 32'h103, 0, 5'd4, 1, RES_MEM, 1, 32'h80FF0000);
    chk("lbu const", readdata_w, 32'h00000080);
    do_op("sh", 1, 0, 1, F3_H, 32'h102, 32'h1234ABCD, 5'd0, 0, RES_ALU, 0, 0);
    do_op("lw_slow", 1, 1, 0, F3_W, 32'h200, 0, 5'd7, 1, RES_MEM, 3, 32'h13579BDF);
    do_op("lh_mis", 1, 1, 0, F3_H, 32'h101, 0, 5'd8, 1, RES_MEM, 0, 0);
    do_op("both", 1, 1, 1, F3_W, 32'h100, 0, 5'd8, 1, RES_MEM, 0, 0);
    do_op("alu", 1, 0, 0, F3_W, 32'h0BADF00D, 0, 5'd9, 1, RES_ALU, 0, 0);
    do_op("pc4", 1, 0, 0, F3_W, 32'h44, 0, 5'd1, 1, RES_PC4, 0, 0);

    // Bus timeout: ack never returns
    valid_m = 1; memread_m = 1; memwrite_m = 0; funct3_m = F3_W; alu_result_m = 32'h300;
    regwrite_m = 1; rd_m = 5'd2; dmem_ack = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!dmem_req) break;
      n++;
      @(posedge clk); #1;
    end
    chk("timeout req_cycles", n, 1 + TO);
    chk("timeout abort_stall", stall_mem, 0);
    @(posedge clk); #1;
    chk("timeout exc_bus", exc_bus, 1);
    chk("timeout regwrite_w", regwrite_w, 0);
    valid_m = 0; memread_m = 0;
    @(posedge clk); #1;
    chk("timeout exc_bus_once", exc_bus, 0);
    do_op("after_to", 1, 1, 0, F3_HU, 32'h306, 0, 5'd5, 1, RES_MEM, 1, 32'hCAFE1234);

    // Reset while BUSY
    valid_m = 1; memread_m = 1; funct3_m = F3_W; alu_result_m = 32'h400; rd_m = 5'd6;
    regwrite_m = 1; result_src_m = RES_MEM; pc_plus_4_m = 32'h1234; dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy req", dmem_req, 1);
    reset = 1'b1;
    #1;
    chk("rst_busy req", dmem_req, 0);
    chk("rst_busy stall", stall_mem, 0);
    chk("rst_busy alu_result_w", alu_result_w, 0);
    chk("rst_busy pc_plus_4_w", pc_plus_4_w, 0);
    chk("rst_busy rd_w", rd_w, 0);
    chk("rst_busy result_src_w", result_src_w, 0);
    @(posedge clk); #1;
    reset = 1'b0; valid_m = 0; memread_m = 0;
    @(posedge clk); #1;
    do_op("after_rst", 1, 1, 0, F3_W, 32'h400, 0, 5'd6, 1, RES_MEM, 2, 32'h0F0F0F0F);

    // Randomized instructions
    for (int i = 0; i < 80; i++) begin
      int kind;
      bit vld, mr, mw;
      logic [31:0] a;
      logic [1:0] rs;
      kind = $urandom_range(0, 9);
      vld = (kind != 9);
      mr  = (kind <= 3) || (kind == 8) || (kind == 9);
      mw  = (kind >= 4 && kind <= 6) || (kind == 8);
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a = a - (a % 4);
      rs  = (kind == 7) ? 2'($urandom_range(0, 2)) : RES_MEM;
      do_op($sformatf("rnd%0d", i), vld, mr, mw, 3'($urandom_range(0, 7)), a, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), rs,
            $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
